countdown_timer: RTL and testbench

Countdown timer datapath and control for the stopwatch/clock board: loads a preset hour:min:sec:centisecond value and decrements it once per 10 ms until it reaches zero, then flags completion. It drives the same display path as the stopwatch, using the same output field widths. It is the down-counting counterpart of the stopwatch datapath and contains its own control FSM.

---
 rtl/timer_pkg.sv | 45 ++++
 rtl/time_down_counter.sv | 63 ++++++
 rtl/countdown_timer.sv | 175 +++++++++++++++++
 tb/tb_countdown_timer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the countdown timer: field limits, field widths,
// FSM state encoding and small decode helpers on the time value.
// -----------------------------------------------------------------------------
package timer_pkg;

    localparam int MSEC_MAX = 99;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 7;
    localparam int MIN_W  = 7;
    localparam int HOUR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when the value is exactly 00:00:00:01, i.e. the next decrement
    // lands on zero.
    function automatic logic is_last_tick(
        input logic [MSEC_W-1:0] msec,
        input logic [SEC_W-1:0]  sec,
        input logic [MIN_W-1:0]  min,
        input logic [HOUR_W-1:0] hour
    );
        return (msec == 7'd1) && (sec == 7'd0) && (min == 7'd0) && (hour == 5'd0);
    endfunction

    // True when any field is nonzero.
    function automatic logic is_nonzero(
        input logic [MSEC_W-1:0] msec,
        input logic [SEC_W-1:0]  sec,
        input logic [MIN_W-1:0]  min,
        input logic [HOUR_W-1:0] hour
    );
        return (|msec) || (|sec) || (|min) || (|hour);
    endfunction

endpackage

// File: rtl/time_down_counter.sv
// -----------------------------------------------------------------------------
// time_down_counter
// One digit stage of the countdown chain. Counts down by one whenever
// borrow_in is high; at zero it reloads MAX and raises borrow_out so the next
// stage decrements on the same edge.
// Ports:
//   clk, rst         clock, async active-high reset
//   clear            zero the stage (highest priority)
//   load, load_value capture a preset, saturated to MAX
//   borrow_in        decrement request from the lower stage / prescaler
//   value            current stage value (registered)
//   borrow_out       combinational: value==0 && borrow_in
// -----------------------------------------------------------------------------
module time_down_counter
    import timer_pkg::*;
#(
    parameter int MAX   = 99,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] value,
    output logic             borrow_out
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

    logic [WIDTH-1:0] value_r;
    logic [WIDTH-1:0] value_next_s;

    // Next value: clear, then saturating load, then decrement with reload.
    always_comb begin
        value_next_s = value_r;
        if (clear) begin
            value_next_s = ZERO_V;
        end else if (load) begin
            value_next_s = (load_value > MAX_V) ? MAX_V : load_value;
        end else if (borrow_in) begin
            value_next_s = (value_r == ZERO_V) ? MAX_V : (value_r - ONE_V);
        end else begin
            value_next_s = value_r;
        end
    end

    // Stage value register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= ZERO_V;
        end else begin
            value_r <= value_next_s;
        end
    end

    assign value      = value_r;
    assign borrow_out = (value_r == ZERO_V) && borrow_in;

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// Loads an hh:mm:ss:cc preset and counts it down once per centisecond tick
// (FCOUNT system clocks) until zero, then reports completion.
// Ports:
//   clk, rst                    clock, async active-high reset
//   load + i_msec/i_sec/i_min/i_hour   capture preset (IDLE or DONE only)
//   start / stop / clear        control pulses (priority clear>load>stop>start)
//   msec, sec, min, hour        current value (registered)
//   running, done               FSM state decode
//   done_tick                   one-cycle pulse on entry to DONE
// -----------------------------------------------------------------------------
module countdown_timer
    import timer_pkg::*;
#(
    parameter int FCOUNT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [MSEC_W-1:0] i_msec,
    input  logic [SEC_W-1:0]  i_sec,
    input  logic [MIN_W-1:0]  i_min,
    input  logic [HOUR_W-1:0] i_hour,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    output logic [MSEC_W-1:0] msec,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic              running,
    output logic              done,
    output logic              done_tick
);

    localparam int             PW         = (FCOUNT > 1) ? $clog2(FCOUNT) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(FCOUNT - 1);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);

    state_t          state_r;
    state_t          next_state_s;
    logic [PW-1:0]   presc_r;
    logic            done_tick_r;
    logic            load_ok_s;
    logic            wrap_s;
    logic            running_s;
    logic            done_s;

    logic            msec_borrow_s;
    logic            sec_borrow_s;
    logic            min_borrow_s;
    // RUN never holds a zero value, so the hour stage can never borrow.
    logic            hour_borrow_unused_s;

    // Load is honoured only outside RUN and only if clear is not also present.
    assign load_ok_s = load && !clear && (state_r != RUN);
    // Prescaler wrap drives the decrement; it only advances in RUN.
    assign wrap_s    = (state_r == RUN) && (presc_r == PRESC_LAST);

    time_down_counter #(.MAX(MSEC_MAX), .WIDTH(MSEC_W)) u_msec (
        .clk(clk), .rst(rst), .clear(clear), .load(load_ok_s),
        .load_value(i_msec), .borrow_in(wrap_s),
        .value(msec), .borrow_out(msec_borrow_s)
    );

    time_down_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_sec (
        .clk(clk), .rst(rst), .clear(clear), .load(load_ok_s),
        .load_value(i_sec), .borrow_in(msec_borrow_s),
        .value(sec), .borrow_out(sec_borrow_s)
    );

    time_down_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_min (
        .clk(clk), .rst(rst), .clear(clear), .load(load_ok_s),
        .load_value(i_min), .borrow_in(sec_borrow_s),
        .value(min), .borrow_out(min_borrow_s)
    );

    time_down_counter #(.MAX(HOUR_MAX), .WIDTH(HOUR_W)) u_hour (
        .clk(clk), .rst(rst), .clear(clear), .load(load_ok_s),
        .load_value(i_hour), .borrow_in(min_borrow_s),
        .value(hour), .borrow_out(hour_borrow_unused_s)
    );

    // Prescaler: counts in RUN (including the stop cycle), holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= '0;
        end else if (clear || load_ok_s) begin
            presc_r <= '0;
        end else if (state_r == RUN) begin
            presc_r <= wrap_s ? '0 : (presc_r + PRESC_ONE);
        end else begin
            presc_r <= presc_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; a wrap that empties the value beats a coincident stop.
    always_comb begin
        next_state_s = state_r;
        if (clear) begin
            next_state_s = IDLE;
        end else if (load_ok_s) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && is_nonzero(msec, sec, min, hour)) begin
                        next_state_s = RUN;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                RUN: begin
                    if (wrap_s && is_last_tick(msec, sec, min, hour)) begin
                        next_state_s = DONE;
                    end else if (stop) begin
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = RUN;
                    end
                end
                DONE:    next_state_s = DONE;
                default: next_state_s = IDLE;
            endcase
        end
    end

    // FSM output decode from the state register.
    always_comb begin
        running_s = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                running_s = 1'b0;
                done_s    = 1'b0;
            end
            RUN: begin
                running_s = 1'b1;
                done_s    = 1'b0;
            end
            DONE: begin
                running_s = 1'b0;
                done_s    = 1'b1;
            end
            default: begin
                running_s = 1'b0;
                done_s    = 1'b0;
            end
        endcase
    end

    // Completion pulse, registered on the RUN->DONE edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_tick_r <= 1'b0;
        end else begin
            done_tick_r <= (state_r == RUN) && (next_state_s == DONE);
        end
    end

    assign running   = running_s;
    assign done      = done_s;
    assign done_tick = done_tick_r;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
// Scoreboard bench: stimulus pushes hand-computed snapshots tagged with the
// clock edge after which they must hold; a monitor pops and compares them on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [6:0] i_msec = 7'd0;
    logic [6:0] i_sec = 7'd0;
    logic [6:0] i_min = 7'd0;
    logic [4:0] i_hour = 5'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] msec;
    logic [6:0] sec;
    logic [6:0] min;
    logic [4:0] hour;
    logic       running;
    logic       done;
    logic       done_tick;

    countdown_timer #(.FCOUNT(10)) dut (
        .clk(clk), .rst(rst), .load(load),
        .i_msec(i_msec), .i_sec(i_sec), .i_min(i_min), .i_hour(i_hour),
        .start(start), .stop(stop), .clear(clear),
        .msec(msec), .sec(sec), .min(min), .hour(hour),
        .running(running), .done(done), .done_tick(done_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic [28:0] want;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [28:0] got;

    // Monitor: compare every snapshot due at or before the current edge count.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            got = {hour, min, sec, msec, running, done, done_tick};
            n_cmp = n_cmp + 1;
            if (cur.cyc != cyc || got !== cur.want) begin
                n_bad = n_bad + 1;
                $display("FAIL %s @%0d (due %0d): got h=%0d m=%0d s=%0d cs=%0d run=%b done=%b tick=%b, want h=%0d m=%0d s=%0d cs=%0d run=%b done=%b tick=%b",
                         cur.name, cyc, cur.cyc,
                         got[28:24], got[23:17], got[16:10], got[9:3], got[2], got[1], got[0],
                         cur.want[28:24], cur.want[23:17], cur.want[16:10], cur.want[9:3],
                         cur.want[2], cur.want[1], cur.want[0]);
            end
        end
    end

    task automatic ex(input int c, input string nm, input int h, input int m, input int s,
                      input int cs, input bit r, input bit d, input bit t);
        exp_t x;
        x.cyc  = c;
        x.name = nm;
        x.want = {5'(h), 7'(m), 7'(s), 7'(cs), r, d, t};
        sb.push_back(x);
    endtask

    // Drive a one-cycle pulse so that it is sampled at posedge number e.
    task automatic fire(input int e, input bit do_load, input bit do_start, input bit do_stop,
                        input bit do_clear, input int h, input int m, input int s, input int cs);
        while (cyc < e - 1) @(negedge clk);
        load   = do_load;
        start  = do_start;
        stop   = do_stop;
        clear  = do_clear;
        i_hour = 5'(h);
        i_min  = 7'(m);
        i_sec  = 7'(s);
        i_msec = 7'(cs);
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() > 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d snapshots left unchecked, want 0", sb.size());
            $fatal(1, "scoreboard stalled");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded, want completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int e0;
        int s0;

        // Reset state, during and just after reset.
        ex(2, "reset_held", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        ex(4, "reset_rel", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drain();

        // 00:00:01:05 counts down to zero over 105 ticks.
        b = cyc + 2; e0 = b + 1;
        ex(b,         "A_load",   0, 0, 1, 5,  1'b0, 1'b0, 1'b0);
        ex(e0,        "A_start",  0, 0, 1, 5,  1'b1, 1'b0, 1'b0);
        ex(e0 + 9,    "A_pre1",   0, 0, 1, 5,  1'b1, 1'b0, 1'b0);
        ex(e0 + 10,   "A_dec1",   0, 0, 1, 4,  1'b1, 1'b0, 1'b0);
        ex(e0 + 50,   "A_sec",    0, 0, 1, 0,  1'b1, 1'b0, 1'b0);
        ex(e0 + 60,   "A_borrow", 0, 0, 0, 99, 1'b1, 1'b0, 1'b0);
        ex(e0 + 1049, "A_last",   0, 0, 0, 1,  1'b1, 1'b0, 1'b0);
        ex(e0 + 1050, "A_done",   0, 0, 0, 0,  1'b0, 1'b1, 1'b1);
        ex(e0 + 1051, "A_tick1",  0, 0, 0, 0,  1'b0, 1'b1, 1'b0);
        fire(b,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 5);
        fire(e0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        drain();

        // Borrow through every field, then stop and clear.
        b = cyc + 2; e0 = b + 1;
        ex(b,       "B_load",  1, 0, 0, 0,   1'b0, 1'b0, 1'b0);
        ex(e0,      "B_start", 1, 0, 0, 0,   1'b1, 1'b0, 1'b0);
        ex(e0 + 9,  "B_pre",   1, 0, 0, 0,   1'b1, 1'b0, 1'b0);
        ex(e0 + 10, "B_dec",   0, 59, 59, 99, 1'b1, 1'b0, 1'b0);
        ex(e0 + 11, "B_stop",  0, 59, 59, 99, 1'b0, 1'b0, 1'b0);
        ex(e0 + 12, "B_clear", 0, 0, 0, 0,   1'b0, 1'b0, 1'b0);
        fire(b,       1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0);
        fire(e0,      1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        fire(e0 + 11, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        fire(e0 + 12, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        drain();

        // Pause after 4 clocks keeps the partial tick.
        b = cyc + 2; e0 = b + 1; s0 = e0 + 54;
        ex(b,      "C_load",   0, 0, 0, 20, 1'b0, 1'b0, 1'b0);
        ex(e0 + 4, "C_stop",   0, 0, 0, 20, 1'b0, 1'b0, 1'b0);
        ex(e0 + 30,"C_paused", 0, 0, 0, 20, 1'b0, 1'b0, 1'b0);
        ex(s0,     "C_resume", 0, 0, 0, 20, 1'b1, 1'b0, 1'b0);
        ex(s0 + 5, "C_pre",    0, 0, 0, 20, 1'b1, 1'b0, 1'b0);
        ex(s0 + 6, "C_dec",    0, 0, 0, 19, 1'b1, 1'b0, 1'b0);
        ex(s0 + 8, "C_clear",  0, 0, 0, 0,  1'b0, 1'b0, 1'b0);
        fire(b,      1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 20);
        fire(e0,     1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        fire(e0 + 4, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        fire(s0,     1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        fire(s0 + 8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        drain();

        // Zero start ignored, saturating load, load ignored in RUN, clear beats load.
        b = cyc + 2;
        ex(b,      "D_loadz",   0, 0, 0, 0,   1'b0, 1'b0, 1'b0);
        ex(b + 1,  "D_startz",  0, 0, 0, 0,   1'b0, 1'b0, 1'b0);
        ex(b + 3,  "D_idle",    0, 0, 0, 0,   1'b0, 1'b0, 1'b0);
        ex(b + 4,  "D_sat",     7, 59, 59, 99, 1'b0, 1'b0, 1'b0);
        ex(b + 5,  "E_start",   7, 59, 59, 99, 1'b1, 1'b0, 1'b0);
        ex(b + 8,  "E_loadrun", 7, 59, 59, 99, 1'b1, 1'b0, 1'b0);
        ex(b + 15, "E_dec",     7, 59, 59, 98, 1'b1, 1'b0, 1'b0);
        ex(b + 17, "E_clrld",   0, 0, 0, 0,   1'b0, 1'b0, 1'b0);
        ex(b + 18, "E_idle",    0, 0, 0, 0,   1'b0, 1'b0, 1'b0);
        fire(b,      1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        fire(b + 1,  1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        fire(b + 4,  1'b1, 1'b0, 1'b0, 1'b0, 7, 70, 70, 120);
        fire(b + 5,  1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        fire(b + 8,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 5);
        fire(b + 17, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0, 5);
        drain();

        // Async reset at 00:00:00:01 mid-count: no completion afterwards.
        b = cyc + 2; e0 = b + 1;
        ex(b,       "F_load",  0, 0, 0, 2, 1'b0, 1'b0, 1'b0);
        ex(e0,      "F_start", 0, 0, 0, 2, 1'b1, 1'b0, 1'b0);
        ex(e0 + 10, "F_dec",   0, 0, 0, 1, 1'b1, 1'b0, 1'b0);
        ex(e0 + 15, "F_rst",   0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        ex(e0 + 20, "F_nowrap",0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        ex(e0 + 21, "F_notick",0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        fire(b,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 2);
        fire(e0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        while (cyc < e0 + 14) @(negedge clk);
        #1 rst = 1'b1;
        while (cyc < e0 + 22) @(negedge clk);
        rst = 1'b0;
        drain();

        // Stop coincident with the final wrap ends in DONE, then load exits DONE.
        b = cyc + 2; e0 = b + 1;
        ex(b,       "G_load",  0, 0, 0, 1, 1'b0, 1'b0, 1'b0);
        ex(e0 + 9,  "G_pre",   0, 0, 0, 1, 1'b1, 1'b0, 1'b0);
        ex(e0 + 10, "G_done",  0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        ex(e0 + 11, "G_tick1", 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        ex(e0 + 13, "G_reload",0, 0, 0, 3, 1'b0, 1'b0, 1'b0);
        fire(b,       1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1);
        fire(e0,      1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        fire(e0 + 10, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        fire(e0 + 13, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3);
        drain();

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
